// File: rtl/hdc_pkg.sv
// hdc_pkg: shared HDC associative-memory sizes and query FSM states
package hdc_pkg;
    localparam int DIM     = 1024;
    localparam int CLS_NUM = 16;
    localparam int CHUNK   = 64;
    localparam int NCHUNK  = DIM / CHUNK;
    localparam int CLS_DW  = (CLS_NUM > 1) ? $clog2(CLS_NUM) : 1;
    localparam int SIM_DW  = $clog2(DIM + 1);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/hv_popcnt.sv
// hv_popcnt: combinational population count of a W-bit vector
module hv_popcnt #(
    parameter int W = 64
) (
    input  logic [W-1:0]           vec,
    output logic [$clog2(W+1)-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) cnt = cnt + $bits(cnt)'(vec[i]);
    end
endmodule

// File: rtl/am_query.sv
// am_query: class-hypervector store with a chunked Hamming-similarity best-match query
module am_query
    import hdc_pkg::*;
#(
    parameter int DIM     = hdc_pkg::DIM,
    parameter int CLS_NUM = hdc_pkg::CLS_NUM,
    parameter int CHUNK   = hdc_pkg::CHUNK,
    localparam int NCHUNK = DIM / CHUNK,
    localparam int CLS_DW = (CLS_NUM > 1) ? $clog2(CLS_NUM) : 1,
    localparam int SIM_DW = $clog2(DIM + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    output logic              wr_ready,
    input  logic [CLS_DW-1:0] wr_addr,
    input  logic [DIM-1:0]    wr_data,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [DIM-1:0]    q_data,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [CLS_DW-1:0] r_label,
    output logic [SIM_DW-1:0] r_simi,
    output logic              r_none
);
    localparam int CHK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PC_W  = $clog2(CHUNK + 1);

    state_t             state, state_nx;
    logic [DIM-1:0]     am [CLS_NUM];
    logic [DIM-1:0]     q_reg;
    logic [CLS_NUM-1:0] written;
    logic [CLS_DW-1:0]  cls, best_label;
    logic [CHK_W-1:0]   chk;
    logic [SIM_DW-1:0]  acc, best_simi, total;
    logic [PC_W-1:0]    pc;
    logic [CHUNK-1:0]   match;
    logic               seen, wr_hit, q_hit, last_chk, last_cls, take;

    assign q_ready  = state == IDLE;
    assign wr_ready = state == IDLE;
    assign r_valid  = state == DONE;
    assign r_label  = best_label;
    assign r_simi   = best_simi;
    assign r_none   = (state == DONE) && !seen;

    assign wr_hit   = wr_en && wr_ready && (32'(wr_addr) < CLS_NUM);
    assign q_hit    = q_valid && q_ready;
    assign match    = ~(q_reg[int'(chk)*CHUNK +: CHUNK] ^ am[cls][int'(chk)*CHUNK +: CHUNK]);
    assign total    = acc + SIM_DW'(pc);
    assign last_chk = chk == CHK_W'(NCHUNK - 1);
    assign last_cls = cls == CLS_DW'(CLS_NUM - 1);
    // The first written class always wins; later ones must be strictly better, so ties keep the lower label
    assign take     = written[cls] && (!seen || total > best_simi);

    hv_popcnt #(.W(CHUNK)) u_popcnt (
        .vec (match),
        .cnt (pc)
    );

    always_comb begin
        state_nx = (state == IDLE && q_hit) ? SCAN :
                   (state == SCAN && last_chk && last_cls) ? DONE :
                   (state == DONE && r_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // Contents are deliberately unreset; validity lives in the written bits
    always_ff @(posedge clk) begin
        if (wr_hit) am[wr_addr] <= wr_data;
        if (q_hit) q_reg <= q_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written    <= '0;
            acc        <= '0;
            best_simi  <= '0;
            best_label <= '0;
            seen       <= 1'b0;
            cls        <= '0;
            chk        <= '0;
        end else begin
            if (wr_hit) written[wr_addr] <= 1'b1;
            if (q_hit) begin
                acc        <= '0;
                best_simi  <= '0;
                best_label <= '0;
                seen       <= 1'b0;
                cls        <= '0;
                chk        <= '0;
            end
            if (state == SCAN) begin
                acc <= last_chk ? '0 : total;
                chk <= last_chk ? '0 : chk + 1'b1;
                if (last_chk) cls <= cls + 1'b1;
                if (last_chk && take) begin
                    best_simi  <= total;
                    best_label <= cls;
                    seen       <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_am_query.sv
// tb_am_query: randomized self-checking bench for am_query against a best-match reference model
module tb_am_query;
    localparam int DIM = 1024;
    localparam int K   = 64;
    localparam int K3  = 48;

    logic            clk = 0;
    logic            rst_n = 0;
    logic            wr_en = 0, q_valid = 0, r_ready = 0;
    logic            wr_ready, q_ready, r_valid, r_none;
    logic [1:0]      wr_addr = 0, r_label;
    logic [DIM-1:0]  wr_data = 0, q_data = 0;
    logic [10:0]     r_simi;

    logic            t_wr_en = 0, t_q_valid = 0, t_r_ready = 0;
    logic            t_wr_ready, t_q_ready, t_r_valid, t_r_none;
    logic [1:0]      t_wr_addr = 0, t_r_label;
    logic [DIM-1:0]  t_wr_data = 0, t_q_data = 0;
    logic [10:0]     t_r_simi;

    logic [DIM-1:0]  m_am [4];
    bit              m_wr [4];
    int              checks = 0, failures = 0;

    always #5 clk = ~clk;

    am_query #(.DIM(DIM), .CLS_NUM(4), .CHUNK(64)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_label(r_label), .r_simi(r_simi), .r_none(r_none)
    );

    am_query #(.DIM(DIM), .CLS_NUM(3), .CHUNK(64)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(t_wr_en), .wr_ready(t_wr_ready), .wr_addr(t_wr_addr),
        .wr_data(t_wr_data), .q_valid(t_q_valid), .q_ready(t_q_ready), .q_data(t_q_data),
        .r_valid(t_r_valid), .r_ready(t_r_ready), .r_label(t_r_label), .r_simi(t_r_simi), .r_none(t_r_none)
    );

    function automatic logic [DIM-1:0] rand_hv();
        logic [DIM-1:0] r;
        for (int i = 0; i < DIM / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void ref_best(input logic [DIM-1:0] q, output int lbl, output int sim, output bit none);
        int s;
        none = 1; lbl = 0; sim = 0;
        for (int c = 0; c < 4; c++) begin
            if (m_wr[c]) begin
                s = $countones(~(q ^ m_am[c]));
                if (none || s > sim) begin lbl = c; sim = s; none = 0; end
            end
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 4; c++) m_wr[c] = 0;
    endtask

    task automatic do_write(input int a, input logic [DIM-1:0] d);
        @(negedge clk);
        wr_en = 1; wr_addr = 2'(a); wr_data = d;
        @(negedge clk);
        wr_en = 0;
        m_am[a] = d; m_wr[a] = 1;
    endtask

    task automatic run_query(input logic [DIM-1:0] q, output int lat, output int lbl, output int sim, output bit none);
        @(negedge clk);
        q_valid = 1; q_data = q;
        @(negedge clk);
        q_valid = 0; lat = 0;
        while (!r_valid && lat < 300) begin @(negedge clk); lat++; end
        lbl = r_label; sim = r_simi; none = r_none;
        r_ready = 1;
        @(negedge clk);
        r_ready = 0;
    endtask

    task automatic t_write(input int a, input logic [DIM-1:0] d);
        @(negedge clk);
        t_wr_en = 1; t_wr_addr = 2'(a); t_wr_data = d;
        @(negedge clk);
        t_wr_en = 0;
    endtask

    task automatic t_wait(output int lat, output int lbl, output int sim, output bit none);
        lat = 0;
        while (!t_r_valid && lat < 300) begin @(negedge clk); lat++; end
        lbl = t_r_label; sim = t_r_simi; none = t_r_none;
        t_r_ready = 1;
        @(negedge clk);
        t_r_ready = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks += 7;
        if (q_ready !== 1'b1) begin failures++; $display("FAIL reset_q_ready got=%b exp=1", q_ready); end
        if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        if (r_valid !== 1'b0) begin failures++; $display("FAIL reset_r_valid got=%b exp=0", r_valid); end
        if (r_label !== 2'd0) begin failures++; $display("FAIL reset_r_label got=%0d exp=0", r_label); end
        if (r_simi !== 11'd0) begin failures++; $display("FAIL reset_r_simi got=%0d exp=0", r_simi); end
        if (r_none !== 1'b0) begin failures++; $display("FAIL reset_r_none got=%b exp=0", r_none); end
        if (t_q_ready !== 1'b1) begin failures++; $display("FAIL reset_t_q_ready got=%b exp=1", t_q_ready); end
    endtask

    task automatic test_empty();
        int lat, lbl, sim, el, es;
        bit none, en;
        logic [DIM-1:0] q;
        apply_reset();
        q = rand_hv();
        run_query(q, lat, lbl, sim, none);
        ref_best(q, el, es, en);
        checks += 4;
        if (lat != K) begin failures++; $display("FAIL empty_latency got=%0d exp=%0d", lat, K); end
        if (none !== en || !en) begin failures++; $display("FAIL empty_none got=%b exp=1", none); end
        if (lbl != 0) begin failures++; $display("FAIL empty_label got=%0d exp=0", lbl); end
        if (sim != 0) begin failures++; $display("FAIL empty_simi got=%0d exp=0", sim); end
        do_write(3, ~q);
        run_query(q, lat, lbl, sim, none);
        ref_best(q, el, es, en);
        checks += 3;
        if (lbl != el) begin failures++; $display("FAIL partial_label got=%0d exp=%0d", lbl, el); end
        if (sim != es) begin failures++; $display("FAIL partial_simi got=%0d exp=%0d", sim, es); end
        if (none !== en) begin failures++; $display("FAIL partial_none got=%b exp=%b", none, en); end
    endtask

    task automatic test_basic();
        int lat, lbl, sim, el, es;
        bit none, en;
        logic [DIM-1:0] q;
        apply_reset();
        do_write(0, '0);
        do_write(1, '1);
        do_write(2, {(DIM/2){2'b10}});
        do_write(3, {{(DIM-8){1'b1}}, 8'h00});
        q = '1;
        run_query(q, lat, lbl, sim, none);
        ref_best(q, el, es, en);
        checks += 4;
        if (lat != K) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, K); end
        if (lbl != el) begin failures++; $display("FAIL basic_label got=%0d exp=%0d", lbl, el); end
        if (sim != es) begin failures++; $display("FAIL basic_simi got=%0d exp=%0d", sim, es); end
        if (none !== en) begin failures++; $display("FAIL basic_none got=%b exp=%b", none, en); end
    endtask

    task automatic test_tie();
        int lat, lbl, sim, el, es;
        bit none, en;
        logic [DIM-1:0] q;
        q = rand_hv();
        do_write(0, q);
        do_write(1, ~q);
        do_write(2, q);
        do_write(3, ~q);
        run_query(q, lat, lbl, sim, none);
        ref_best(q, el, es, en);
        checks += 2;
        if (lbl != el) begin failures++; $display("FAIL tie_label got=%0d exp=%0d", lbl, el); end
        if (sim != es) begin failures++; $display("FAIL tie_simi got=%0d exp=%0d", sim, es); end
    endtask

    task automatic test_random();
        int lat, lbl, sim, el, es;
        bit none, en;
        logic [DIM-1:0] q;
        apply_reset();
        for (int it = 0; it < 8; it++) begin
            q = rand_hv();
            for (int c = 0; c < 4; c++)
                if ($urandom_range(3) != 0) do_write(c, q ^ (rand_hv() & rand_hv() & rand_hv()));
            run_query(q, lat, lbl, sim, none);
            ref_best(q, el, es, en);
            checks += 4;
            if (lat != K) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, lat, K); end
            if (lbl != el) begin failures++; $display("FAIL rand%0d_label got=%0d exp=%0d", it, lbl, el); end
            if (sim != es) begin failures++; $display("FAIL rand%0d_simi got=%0d exp=%0d", it, sim, es); end
            if (none !== en) begin failures++; $display("FAIL rand%0d_none got=%b exp=%b", it, none, en); end
        end
    endtask

    task automatic test_backpressure();
        int lat, lbl, sim, el, es;
        bit none, en;
        logic [DIM-1:0] q;
        q = rand_hv();
        ref_best(q, el, es, en);
        @(negedge clk);
        q_valid = 1; q_data = q;
        @(negedge clk);
        q_valid = 0; lat = 0;
        while (!r_valid && lat < 300) begin @(negedge clk); lat++; end
        checks++;
        if (lat != K) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, K); end
        for (int i = 0; i < 10; i++) begin
            wr_en = 1; wr_addr = 2'd0; wr_data = q; q_valid = 1; q_data = ~q;
            @(negedge clk);
            checks += 3;
            if (r_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, r_valid); end
            if (r_label !== 2'(el) || r_simi !== 11'(es)) begin
                failures++; $display("FAIL bp_hold_result cyc=%0d got=%0d/%0d exp=%0d/%0d", i, r_label, r_simi, el, es);
            end
            if (q_ready !== 1'b0 || wr_ready !== 1'b0) begin
                failures++; $display("FAIL bp_ready cyc=%0d got=%b/%b exp=0/0", i, q_ready, wr_ready);
            end
        end
        wr_en = 0; q_valid = 0; r_ready = 1;
        @(negedge clk);
        r_ready = 0;
        checks++;
        if (r_valid !== 1'b0 || q_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release got=%b/%b exp=0/1", r_valid, q_ready);
        end
        run_query(q, lat, lbl, sim, none);
        checks += 2;
        if (lbl != el) begin failures++; $display("FAIL bp_nowrite_label got=%0d exp=%0d", lbl, el); end
        if (sim != es) begin failures++; $display("FAIL bp_nowrite_simi got=%0d exp=%0d", sim, es); end
    endtask

    task automatic test_reset_mid_scan();
        int lat, lbl, sim, el, es;
        bit none, en;
        logic [DIM-1:0] q;
        q = rand_hv();
        do_write(2, q);
        @(negedge clk);
        q_valid = 1; q_data = q;
        @(negedge clk);
        q_valid = 0;
        repeat (20) @(negedge clk);
        rst_n = 0;
        #1;
        checks += 2;
        if (r_valid !== 1'b0) begin failures++; $display("FAIL midrst_r_valid got=%b exp=0", r_valid); end
        if (q_ready !== 1'b1) begin failures++; $display("FAIL midrst_q_ready got=%b exp=1", q_ready); end
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 4; c++) m_wr[c] = 0;
        run_query(q, lat, lbl, sim, none);
        ref_best(q, el, es, en);
        checks += 2;
        if (lat != K) begin failures++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, K); end
        if (none !== en || !en) begin failures++; $display("FAIL midrst_none got=%b exp=1", none); end
    endtask

    task automatic test_wr_corner();
        int lat, lbl, sim;
        bit none;
        logic [DIM-1:0] q, q2;
        apply_reset();
        q = rand_hv();
        q2 = rand_hv();
        t_write(3, q);
        @(negedge clk);
        t_q_valid = 1; t_q_data = q;
        @(negedge clk);
        t_q_valid = 0;
        t_wait(lat, lbl, sim, none);
        checks += 3;
        if (lat != K3) begin failures++; $display("FAIL oob_latency got=%0d exp=%0d", lat, K3); end
        if (none !== 1'b1) begin failures++; $display("FAIL oob_none got=%b exp=1", none); end
        if (sim != 0) begin failures++; $display("FAIL oob_simi got=%0d exp=0", sim); end
        t_write(1, ~q2);
        @(negedge clk);
        t_wr_en = 1; t_wr_addr = 2'd1; t_wr_data = q2; t_q_valid = 1; t_q_data = q2;
        @(negedge clk);
        t_wr_en = 0; t_q_valid = 0;
        t_wait(lat, lbl, sim, none);
        checks += 3;
        if (lbl != 1) begin failures++; $display("FAIL same_cycle_label got=%0d exp=1", lbl); end
        if (sim != DIM) begin failures++; $display("FAIL same_cycle_simi got=%0d exp=%0d", sim, DIM); end
        if (none !== 1'b0) begin failures++; $display("FAIL same_cycle_none got=%b exp=0", none); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_basic();
        test_tie();
        test_random();
        test_backpressure();
        test_reset_mid_scan();
        test_wr_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/am_query.md
Name: am_query

Overview:
- Query side of the HDC associative memory; it is the reader for the class hypervectors that training writes.
- Holds CLS_NUM class hypervectors, written from the training path (tempo encoder output plus label).
- Accepts one query hypervector per valid/ready handshake and scans every written class sequentially, CHUNK bits per cycle.
- Returns the label with maximum Hamming similarity and its similarity count through a valid/ready result port.

Parameters:
- DIM, 1024, hypervector width in bits.
- CLS_NUM, 16, number of class entries.
- CHUNK, 64, bits compared per cycle; DIM must be a multiple of CHUNK.
- Derived: NCHUNK=DIM/CHUNK; CLS_DW=max(1,$clog2(CLS_NUM)); SIM_DW=$clog2(DIM+1); K=CLS_NUM*NCHUNK.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write one class entry.
- wr_ready  out  1  write accepted when wr_en & wr_ready.
- wr_addr  in  CLS_DW  class label to write.
- wr_data  in  DIM  class hypervector.
- q_valid  in  1  query present.
- q_ready  out  1  query accepted when q_valid & q_ready.
- q_data  in  DIM  query hypervector.
- r_valid  out  1  result present.
- r_ready  in  1  result consumed when r_valid & r_ready.
- r_label  out  CLS_DW  best class.
- r_simi  out  SIM_DW  matching-bit count of best class, 0..DIM.
- r_none  out  1  no class has been written since reset.

Behaviour:
- Reset:
  - state=IDLE; q_ready=1, wr_ready=1, r_valid=0, r_label=0, r_simi=0, r_none=0.
  - All per-class written bits cleared. AM contents are not reset.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - q_ready=wr_ready=1.
  - A write with wr_addr<CLS_NUM stores wr_data and sets the written bit. A write with wr_addr>=CLS_NUM is ignored.
  - A query handshake latches q_data, clears the accumulator and best registers, and goes to SCAN with cls=0, chk=0.
  - If a write and a query arrive in the same cycle, both are accepted. The query scans the newly written value.
- SCAN:
  - q_ready=wr_ready=0.
  - Each cycle: acc += popcount(~(q[chk] ^ AM[cls][chk])), where [chk] is bits chk*CHUNK+CHUNK-1 : chk*CHUNK.
  - On chk=NCHUNK-1, the class total (acc plus this chunk) is compared in the same edge. It replaces best when:
    - the class is written, AND
    - either no written class has been seen yet or total > best_simi (strict).
  - Ties therefore keep the lower label. acc then clears, chk wraps to 0, cls increments.
  - Unwritten classes still take NCHUNK cycles, giving fixed latency.
  - After the last chunk of class CLS_NUM-1, go to DONE.
- Latency: the query is accepted on edge E0 and r_valid is high after edge E0+K; latency is exactly K cycles.
- DONE:
  - r_valid=1; r_label/r_simi hold the best class and its count.
  - r_none=1 with r_label=0, r_simi=0 when no class was written.
  - Outputs are stable until r_ready. On handshake go to IDLE and drop r_valid. q_ready rises the cycle after.
- Back-to-back queries therefore need K+2 cycles each.
- Arithmetic:
  - Per-chunk popcount is $clog2(CHUNK+1) bits, zero-extended into the SIM_DW accumulator.
  - No overflow is possible, since the maximum is DIM.
- Reset asserted mid-SCAN or mid-DONE:
  - Returns to IDLE immediately (asynchronous) and the in-flight query is dropped.
  - The written bits are cleared, so the AM is logically empty.

Decomposition:
- hdc_pkg holds DIM, CLS_NUM, CHUNK and the derived NCHUNK, CLS_DW, SIM_DW, plus the state enum {IDLE, SCAN, DONE}.
- Sub-module hv_popcnt: parameter W; purely combinational popcount of a W-bit vector; output width $clog2(W+1).
- am_query instantiates one hv_popcnt with W=CHUNK.

Test Plan:
All scenarios use DIM=1024, CHUNK=64, CLS_NUM=4 (NCHUNK=16, K=64) unless stated.
1. Basic match.
   - Stimulus: write class0 all-0, class1 all-1, class2 0xAAAA…, class3 all-1 except bits[7:0]=0; query all-1.
   - Required response: r_valid exactly 64 cycles after accept, r_label=1, r_simi=1024, r_none=0.
2. Tie break.
   - Stimulus: class0 = class2 = Q; class1/class3 = ~Q; query Q.
   - Required response: r_label=0, r_simi=1024.
3. Empty and partial AM.
   - Stimulus: query immediately after reset.
   - Required response: r_none=1, r_label=0, r_simi=0.
   - Stimulus: then write only class3 = ~Q, query Q.
   - Required response: r_label=3, r_simi=0, r_none=0.
4. Backpressure.
   - Stimulus: hold r_ready=0 for 10 cycles after r_valid; drive wr_en/q_valid throughout.
   - Required response: r_valid/r_label/r_simi stable; q_ready=wr_ready=0; no write lands. After r_ready, q_ready=1 one cycle later.
5. Reset mid-scan.
   - Stimulus: assert rst_n=0 at scan cycle 20.
   - Required response: r_valid=0 and q_ready=1 immediately. The next query returns r_none=1.
6. Write corner cases.
   - Stimulus: with CLS_NUM=3, write to addr 3; separately, issue a same-cycle write to class1 plus a query.
   - Required response: the addr-3 write is ignored (query Q with only that write gives r_none=1). The same-cycle query sees the new class1 value.
